// File: rtl/bch_pkg.sv
// Shared definitions for the BCH test-chain flow controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package bch_pkg;

  localparam int TIMEOUT_CYCLES_DEF = 1024;
  localparam int ERR_MAX_DEF        = 4;

  // Stage codes as seen on the stage status output.
  localparam logic [2:0] STAGE_IDLE   = 3'd0;
  localparam logic [2:0] STAGE_ENCODE = 3'd1;
  localparam logic [2:0] STAGE_NOISE  = 3'd2;
  localparam logic [2:0] STAGE_ERRORS = 3'd3;
  localparam logic [2:0] STAGE_DECODE = 3'd4;
  localparam logic [2:0] STAGE_DONE   = 3'd5;
  localparam logic [2:0] STAGE_FAULT  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = STAGE_IDLE,
    ST_ENCODE = STAGE_ENCODE,
    ST_NOISE  = STAGE_NOISE,
    ST_ERRORS = STAGE_ERRORS,
    ST_DECODE = STAGE_DECODE,
    ST_DONE   = STAGE_DONE,
    ST_FAULT  = STAGE_FAULT
  } state_e;

  typedef struct packed {
    logic enc_en;
    logic noise_en;
    logic err_en;
    logic dec_en;
  } stage_en_t;

  // First enabled stage strictly after cur in pipeline order, else DONE.
  // Only meaningful for cur in IDLE..DECODE, which is how it is used.
  function automatic state_e next_stage(input state_e cur, input stage_en_t en);
    if (cur < ST_ENCODE && en.enc_en)   return ST_ENCODE;
    if (cur < ST_NOISE  && en.noise_en) return ST_NOISE;
    if (cur < ST_ERRORS && en.err_en)   return ST_ERRORS;
    if (cur < ST_DECODE && en.dec_en)   return ST_DECODE;
    return ST_DONE;
  endfunction

endpackage

// File: rtl/bch_stage_timer.sv
// Per-stage cycle counter; flags when a stage has used its whole time budget.
// Latency: expired is combinational from the count register (count 0 on the entry cycle).
// Backpressure: none; counter saturates at TIMEOUT_CYCLES-1 while enabled.
//
// Ports: clk, rstn (async active-low), clear (restart at 0 next edge),
//        enable (count this cycle), expired (count reached TIMEOUT_CYCLES-1).
module bch_stage_timer
  import bch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int             CW   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  assign expired = enable && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/bch_flow_ctrl.sv
// Sequences one BCH test run through encode / noise / error-inject / decode stages.
// Latency: cfg_start at edge N gives the first *_start in cycle N+1; disabled stages cost 0 cycles.
// Backpressure: cfg_start is ignored outside IDLE; each stage holds until its done or a timeout.
//
// Ports: clk, rstn (async active-low); cfg_start/cfg_abort/fault_clr pulses;
//        cfg_*_en stage enables and cfg_err_num (latched at run start);
//        *_start out / *_done in per stage; err_num_o latched error count;
//        busy, run_done (pulse), fault, stage (state code), run_cnt (wrapping).
module bch_flow_ctrl
  import bch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int ERR_MAX        = ERR_MAX_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cfg_start,
  input  logic        cfg_abort,
  input  logic        fault_clr,
  input  logic        cfg_enc_en,
  input  logic        cfg_noise_en,
  input  logic        cfg_err_en,
  input  logic        cfg_dec_en,
  input  logic [3:0]  cfg_err_num,
  output logic        enc_start,
  output logic        noise_start,
  output logic        err_start,
  output logic        dec_start,
  input  logic        enc_done,
  input  logic        noise_done,
  input  logic        err_done,
  input  logic        dec_done,
  output logic [3:0]  err_num_o,
  output logic        busy,
  output logic        run_done,
  output logic        fault,
  output logic [2:0]  stage,
  output logic [15:0] run_cnt
);

  state_e        state_q, state_d;
  stage_en_t     en_in, en_q;
  logic [3:0]    err_num_q;
  logic [15:0]   run_cnt_q;
  logic          entered_q;   // first cycle in the current state
  logic          in_stage;
  logic          act_done;
  logic          done_s;
  logic          expired;
  logic          cfg_bad;

  assign en_in   = {cfg_enc_en, cfg_noise_en, cfg_err_en, cfg_dec_en};
  assign cfg_bad = cfg_err_en && ((cfg_err_num == 4'd0) || (int'(cfg_err_num) > ERR_MAX));

  assign in_stage = (state_q == ST_ENCODE) || (state_q == ST_NOISE) ||
                    (state_q == ST_ERRORS) || (state_q == ST_DECODE);

  // Only the active stage's done counts, and never on its start cycle.
  always_comb begin
    act_done = 1'b0;
    case (state_q)
      ST_ENCODE: act_done = enc_done;
      ST_NOISE:  act_done = noise_done;
      ST_ERRORS: act_done = err_done;
      ST_DECODE: act_done = dec_done;
      default:   act_done = 1'b0;
    endcase
  end
  assign done_s = act_done && !entered_q;

  bch_stage_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (state_d != state_q),
    .enable  (in_stage),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    enc_start   = 1'b0;
    noise_start = 1'b0;
    err_start   = 1'b0;
    dec_start   = 1'b0;
    run_done    = 1'b0;
    fault       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) state_d = cfg_bad ? ST_FAULT : next_stage(ST_IDLE, en_in);
      end
      ST_ENCODE, ST_NOISE, ST_ERRORS, ST_DECODE: begin
        enc_start   = (state_q == ST_ENCODE) && entered_q;
        noise_start = (state_q == ST_NOISE)  && entered_q;
        err_start   = (state_q == ST_ERRORS) && entered_q;
        dec_start   = (state_q == ST_DECODE) && entered_q;
        // done beats a coincident timeout
        if (done_s)       state_d = next_stage(state_q, en_q);
        else if (expired) state_d = ST_FAULT;
      end
      ST_DONE: begin
        run_done = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_FAULT: begin
        fault = 1'b1;
        if (fault_clr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // abort overrides every other transition
    if (cfg_abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      entered_q <= 1'b0;
      en_q      <= '0;
      err_num_q <= '0;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      entered_q <= (state_d != state_q);
      if ((state_q == ST_IDLE) && cfg_start) begin
        en_q      <= en_in;
        err_num_q <= cfg_err_num;
      end
      if (state_q == ST_DONE) run_cnt_q <= run_cnt_q + 16'd1;
    end
  end

  assign busy      = in_stage;
  assign stage     = state_q;
  assign err_num_o = err_num_q;
  assign run_cnt   = run_cnt_q;

endmodule

// File: tb/tb_bch_flow_ctrl.sv
// Directed bench for bch_flow_ctrl with a small auto-responder for stage done.
// Latency: n/a.
// Backpressure: n/a.
module tb_bch_flow_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_start, cfg_abort, fault_clr;
  logic        cfg_enc_en, cfg_noise_en, cfg_err_en, cfg_dec_en;
  logic [3:0]  cfg_err_num;
  logic        enc_start, noise_start, err_start, dec_start;
  logic [3:0]  done_v;
  logic [3:0]  err_num_o;
  logic        busy, run_done, fault;
  logic [2:0]  stage;
  logic [15:0] run_cnt;
  logic [3:0]  start_v;

  assign start_v = {dec_start, err_start, noise_start, enc_start};

  always #5 clk = ~clk;

  bch_flow_ctrl #(.TIMEOUT_CYCLES(TO), .ERR_MAX(4)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cfg_start    (cfg_start),
    .cfg_abort    (cfg_abort),
    .fault_clr    (fault_clr),
    .cfg_enc_en   (cfg_enc_en),
    .cfg_noise_en (cfg_noise_en),
    .cfg_err_en   (cfg_err_en),
    .cfg_dec_en   (cfg_dec_en),
    .cfg_err_num  (cfg_err_num),
    .enc_start    (enc_start),
    .noise_start  (noise_start),
    .err_start    (err_start),
    .dec_start    (dec_start),
    .enc_done     (done_v[0]),
    .noise_done   (done_v[1]),
    .err_done     (done_v[2]),
    .dec_done     (done_v[3]),
    .err_num_o    (err_num_o),
    .busy         (busy),
    .run_done     (run_done),
    .fault        (fault),
    .stage        (stage),
    .run_cnt      (run_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_start[4];
  int st_cyc[4];
  int cd[4];
  int order_q[$];
  int n_rd;
  bit auto_done;
  int t0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  task automatic clr_log();
    for (int i = 0; i < 4; i++) begin
      n_start[i] = 0;
      st_cyc[i]  = -1;
      cd[i]      = 0;
    end
    order_q.delete();
    n_rd = 0;
  endtask

  task automatic set_cfg(input bit e, input bit n, input bit r, input bit d, input int num);
    cfg_enc_en   = e;
    cfg_noise_en = n;
    cfg_err_en   = r;
    cfg_dec_en   = d;
    cfg_err_num  = 4'(num);
  endtask

  // Advance one cycle, land 1 time unit after the edge, log outputs and
  // optionally answer each start with a done three cycles later.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (start_v[i]) begin
        n_start[i]++;
        st_cyc[i] = cyc;
        order_q.push_back(i);
      end
    end
    if (run_done) n_rd++;
    if (auto_done) begin
      for (int i = 0; i < 4; i++) begin
        done_v[i] = 1'b0;
        if (cd[i] > 0) begin
          cd[i]--;
          if (cd[i] == 0) done_v[i] = 1'b1;
        end
        if (start_v[i]) cd[i] = 3;
      end
    end
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && stage != 3'd0; i++) tick();
    check({tag, ".idle"}, int'(stage), 0);
  endtask

  initial begin
    rstn = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; fault_clr = 1'b0;
    done_v = 4'b0; auto_done = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    clr_log();

    #2;
    check("rst.stage",   int'(stage),     0);
    check("rst.busy",    int'(busy),      0);
    check("rst.fault",   int'(fault),     0);
    check("rst.run_cnt", int'(run_cnt),   0);
    check("rst.err_num", int'(err_num_o), 0);
    check("rst.starts",  int'(start_v),   0);
    check("rst.run_done",int'(run_done),  0);
    @(posedge clk); #1;
    rstn = 1'b1;
    tick();

    // Full run, all stages, done 3 cycles after each start; cfg changed
    // after start to confirm it was latched.
    clr_log(); auto_done = 1'b1;
    set_cfg(1, 1, 1, 1, 2);
    pulse_start();
    check("full.enc_start", int'(enc_start), 1);
    check("full.busy",      int'(busy),      1);
    check("full.err_num",   int'(err_num_o), 2);
    set_cfg(0, 0, 0, 0, 0);
    wait_idle("full", 40);
    check("full.nstarts", order_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < order_q.size()) check($sformatf("full.order%0d", i), order_q[i], i);
      check($sformatf("full.cyc%0d", i), st_cyc[i], t0 + 4 * i);
    end
    check("full.run_done", n_rd, 1);
    check("full.run_cnt",  int'(run_cnt),   1);
    check("full.err_hold", int'(err_num_o), 2);
    auto_done = 1'b0; done_v = 4'b0;

    // Only decode enabled: dec_start right after the start edge.
    clr_log(); auto_done = 1'b1;
    set_cfg(0, 0, 0, 1, 0);
    pulse_start();
    check("skip.stage",     int'(stage),     4);
    check("skip.dec_start", int'(dec_start), 1);
    wait_idle("skip", 20);
    check("skip.others",  n_start[0] + n_start[1] + n_start[2], 0);
    check("skip.dec_n",   n_start[3], 1);
    check("skip.dec_cyc", st_cyc[3],  t0);
    check("skip.run_cnt", int'(run_cnt), 2);
    auto_done = 1'b0; done_v = 4'b0;

    // Done on the start cycle is ignored; done at the last budget cycle wins over timeout.
    clr_log();
    set_cfg(1, 0, 0, 0, 0);
    pulse_start();
    done_v[0] = 1'b1;
    tick();
    done_v[0] = 1'b0;
    check("ign.stage", int'(stage), 1);
    repeat (6) tick();
    done_v[0] = 1'b1;
    tick();
    done_v[0] = 1'b0;
    check("prio.stage",    int'(stage),    5);
    check("prio.run_done", int'(run_done), 1);
    tick();
    check("prio.idle",    int'(stage),   0);
    check("prio.run_cnt", int'(run_cnt), 3);

    // Timeout: enc_done never arrives.
    clr_log();
    set_cfg(1, 0, 0, 0, 0);
    pulse_start();
    repeat (TO - 1) tick();
    check("to.last_cycle", int'(stage), 1);
    tick();
    check("to.stage", int'(stage), 6);
    check("to.fault", int'(fault), 1);
    check("to.busy",  int'(busy),  0);
    done_v[0] = 1'b1;
    repeat (2) tick();
    done_v[0] = 1'b0;
    check("to.hold", int'(fault), 1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("to.clr_stage", int'(stage),   0);
    check("to.clr_fault", int'(fault),   0);
    check("to.run_cnt",   int'(run_cnt), 3);
    check("to.enc_n",     n_start[0],    1);

    // Bad error count: above ERR_MAX, and zero.
    clr_log();
    set_cfg(1, 1, 1, 1, 5);
    pulse_start();
    check("bad5.stage",  int'(stage),     6);
    check("bad5.starts", int'(start_v),   0);
    check("bad5.errnum", int'(err_num_o), 5);
    tick();
    check("bad5.nstarts", order_q.size(), 0);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    check("bad5.abort_idle", int'(stage), 0);
    clr_log();
    set_cfg(0, 0, 1, 0, 0);
    pulse_start();
    check("bad0.stage",   int'(stage), 6);
    check("bad0.nstarts", order_q.size(), 0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("bad0.idle", int'(stage), 0);

    // err_num equal to ERR_MAX is legal; cfg_start mid-run is ignored.
    clr_log();
    set_cfg(0, 0, 1, 0, 4);
    pulse_start();
    check("max.stage",     int'(stage),     3);
    check("max.err_start", int'(err_start), 1);
    check("max.errnum",    int'(err_num_o), 4);
    set_cfg(1, 1, 1, 1, 2);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("busy_start.stage",  int'(stage),     3);
    check("busy_start.errnum", int'(err_num_o), 4);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    check("max.abort_idle", int'(stage),   0);
    check("max.run_cnt",    int'(run_cnt), 3);

    // Abort during NOISE together with noise_done.
    clr_log();
    set_cfg(1, 1, 1, 1, 2);
    pulse_start();
    tick();
    done_v[0] = 1'b1;
    tick();
    done_v[0] = 1'b0;
    check("abort.noise_stage", int'(stage),       2);
    check("abort.noise_start", int'(noise_start), 1);
    tick();
    done_v[1] = 1'b1; cfg_abort = 1'b1;
    tick();
    done_v[1] = 1'b0; cfg_abort = 1'b0;
    check("abort.stage", int'(stage), 0);
    repeat (4) tick();
    check("abort.later_starts", n_start[2] + n_start[3], 0);
    check("abort.run_done",     n_rd, 0);
    check("abort.run_cnt",      int'(run_cnt), 3);

    // run_cnt wrap from 0xFFFF on an empty run (IDLE -> DONE -> IDLE).
    dut.run_cnt_q = 16'hFFFF;
    clr_log();
    set_cfg(0, 0, 0, 0, 0);
    pulse_start();
    check("wrap.stage",    int'(stage),    5);
    check("wrap.run_done", int'(run_done), 1);
    tick();
    check("wrap.idle",    int'(stage),   0);
    check("wrap.run_cnt", int'(run_cnt), 0);

    // Reset in the middle of DECODE.
    clr_log();
    set_cfg(0, 0, 0, 1, 3);
    pulse_start();
    tick(); tick();
    check("mid.busy", int'(busy), 1);
    rstn = 1'b0;
    #1;
    check("arst.stage",    int'(stage),     0);
    check("arst.busy",     int'(busy),      0);
    check("arst.starts",   int'(start_v),   0);
    check("arst.fault",    int'(fault),     0);
    check("arst.run_done", int'(run_done),  0);
    check("arst.run_cnt",  int'(run_cnt),   0);
    check("arst.err_num",  int'(err_num_o), 0);
    check("arst.timer",    int'(dut.u_timer.cnt_q), 0);
    #2;
    rstn = 1'b1;
    clr_log();
    done_v[3] = 1'b1;
    repeat (5) tick();
    done_v = 4'b0;
    check("post_rst.stage",   int'(stage), 0);
    check("post_rst.starts",  order_q.size(), 0);
    check("post_rst.run_cnt", int'(run_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bch_flow_ctrl.md
BCH_FLOW_CTRL -- requirements
Module: bch_flow_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, max cycles a stage may take before fault.
REQ-002 SHALL have parameter ERR_MAX, default 4, max injectable errors (BCH correcting capability x2).
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports cfg_start in 1 (run request pulse), cfg_abort in 1 (abort pulse), fault_clr in 1 (clear fault pulse).
REQ-006 SHALL have ports cfg_enc_en, cfg_noise_en, cfg_err_en, cfg_dec_en, each in 1, enabling each stage.
REQ-007 SHALL have port cfg_err_num  in  4  number of bit errors to inject.
REQ-008 SHALL have stage handshake ports enc_start/noise_start/err_start/dec_start out 1 and enc_done/noise_done/err_done/dec_done in 1.
REQ-009 SHALL have port err_num_o  out  4  latched error count to the error injector.
REQ-010 SHALL have status ports busy out 1, run_done out 1 (pulse), fault out 1, stage out 3, run_cnt out 16.

Function
REQ-011 SHALL implement states IDLE, ENCODE, NOISE, ERRORS, DECODE, DONE, FAULT; stage output encodes them 0..6 in that order.
REQ-012 SHALL, in IDLE with cfg_start=1, latch all cfg_* inputs and move to the first enabled stage, order ENCODE, NOISE, ERRORS, DECODE.
REQ-013 SHALL skip disabled stages with zero cycles; with no stage enabled, go IDLE -> DONE.
REQ-014 SHALL assert the stage's *_start for exactly one cycle, the first cycle in that state (cfg_start at edge N -> *_start high during cycle N+1).
REQ-015 SHALL ignore *_done on the cycle *_start is high; sample it from the next cycle onward.
REQ-016 SHALL, on sampled *_done, move to the next enabled stage or DONE on the following edge.
REQ-017 SHALL count cycles per stage from 0, reset on stage entry; at count TIMEOUT_CYCLES-1 without done -> FAULT.
REQ-018 SHALL give done priority when done and timeout coincide.
REQ-019 SHALL, if latched cfg_err_num = 0 or > ERR_MAX with ERRORS enabled, go IDLE -> FAULT without issuing any start.
REQ-020 SHALL hold err_num_o at the latched value from run start until the next run starts.
REQ-021 SHALL, in DONE, pulse run_done one cycle, increment run_cnt (16-bit, wraps 0xFFFF -> 0x0000), return to IDLE.
REQ-022 SHALL hold FAULT with fault=1 until fault_clr or cfg_abort, then IDLE next edge; run_cnt unchanged.
REQ-023 SHALL ignore cfg_start when not in IDLE.
REQ-024 SHALL, on cfg_abort in any non-IDLE state, go IDLE next edge, issue no further *_start; abort has priority over done, timeout and start.
REQ-025 SHALL drive busy=1 in ENCODE, NOISE, ERRORS, DECODE; 0 otherwise.
REQ-026 SHALL ignore *_done of non-active stages.

Reset
REQ-027 SHALL, with rstn low, immediately force state IDLE, all *_start 0, run_done 0, fault 0, busy 0, stage 0, run_cnt 0, err_num_o 0, timer 0.
REQ-028 SHALL, on reset mid-run, discard latched config; first activity after release only on a new cfg_start.

Structure
REQ-029 SHALL place the state enum, stage code constants and default TIMEOUT_CYCLES/ERR_MAX in shared package bch_pkg.
REQ-030 SHALL implement the per-stage timeout counter as sub-module bch_stage_timer (inputs clear, enable; output expired).

Verification
REQ-031 SHALL test full run: all enables, cfg_err_num=2, each done 3 cycles after its start -> starts in order ENCODE..DECODE, run_done once, run_cnt=1, err_num_o=2.
REQ-032 SHALL test skip: only cfg_dec_en=1 -> dec_start at cycle N+1 after start, no other starts.
REQ-033 SHALL test timeout: TIMEOUT_CYCLES=8, enc_done never -> fault=1 after 8 cycles in ENCODE; fault_clr -> IDLE, fault=0.
REQ-034 SHALL test bad config: cfg_err_en=1, cfg_err_num=5 -> FAULT, no *_start pulse.
REQ-035 SHALL test abort during NOISE with noise_done same cycle -> IDLE, no err_start/dec_start, run_cnt unchanged.
REQ-036 SHALL test wrap and reset: preload 0xFFFF runs -> run_cnt=0x0000 after next run; rstn low mid-DECODE -> all outputs reset values same cycle.
